// File: rtl/serial_mag_comparator_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the bit-serial magnitude comparator:
//   state_t     - controller states (IDLE, SHIFT, DONE)
//   rel_t       - 2-bit relation encoding (REL_EQ, REL_LT, REL_GT)
//   leg_t       - one-hot less/equal/greater output bundle
//   rel_to_leg  - maps a relation code onto the l/e/g bundle
// -----------------------------------------------------------------------------
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'b00,
    REL_LT = 2'b01,
    REL_GT = 2'b10
  } rel_t;

  typedef struct packed {
    logic l;
    logic e;
    logic g;
  } leg_t;

  // The unused code 2'b11 cannot be produced by the datapath; treat it as
  // equal so the outputs remain one-hot regardless.
  function automatic leg_t rel_to_leg(input rel_t rel);
    leg_t leg;
    leg = '{l: 1'b0, e: 1'b1, g: 1'b0};
    case (rel)
      REL_LT:  leg = '{l: 1'b1, e: 1'b0, g: 1'b0};
      REL_GT:  leg = '{l: 1'b0, e: 1'b0, g: 1'b1};
      default: leg = '{l: 1'b0, e: 1'b1, g: 1'b0};
    endcase
    return leg;
  endfunction

endpackage

// File: rtl/serial_mag_comparator_if.sv
// -----------------------------------------------------------------------------
// serial_mag_comparator_if
// Bit-serial operand link plus result bundle for serial_mag_comparator.
//   start      - begin a new comparison (master -> slave)
//   bit_valid  - a_bit/b_bit carry a valid pair (master -> slave)
//   a_bit      - serial bit of operand A (master -> slave)
//   b_bit      - serial bit of operand B (master -> slave)
//   bit_ready  - slave accepts a pair this cycle (slave -> master)
//   busy       - comparison in progress (slave -> master)
//   done       - one-cycle completion pulse (slave -> master)
//   l, e, g    - registered A<B, A==B, A>B (slave -> master)
// -----------------------------------------------------------------------------
interface serial_mag_comparator_if;
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic bit_ready;
  logic busy;
  logic done;
  logic l;
  logic e;
  logic g;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  bit_ready, busy, done, l, e, g
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output bit_ready, busy, done, l, e, g
  );
endinterface

// File: rtl/serial_mag_comparator_bit_cmp_cell.sv
// -----------------------------------------------------------------------------
// bit_cmp_cell
// Combinational single-bit magnitude compare.
//   a, b   - input bits
//   lt     - a < b
//   eq     - a == b
//   gt     - a > b
// -----------------------------------------------------------------------------
module bit_cmp_cell (
  input  logic a,
  input  logic b,
  output logic lt,
  output logic eq,
  output logic gt
);

  assign lt = ~a & b;
  assign gt = a & ~b;
  assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_mag_comparator.sv
// -----------------------------------------------------------------------------
// serial_mag_comparator
// Bit-serial WIDTH-bit magnitude comparator. Operand pairs arrive one bit per
// accepted handshake; after WIDTH bits the registered l/e/g outputs load the
// relation of A to B and done pulses for one cycle.
//   Parameters: WIDTH (operand bits, >= 1), MSB_FIRST (1: MSB first, 0: LSB first)
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - serial_mag_comparator_if.slave (start, bit_valid, a_bit, b_bit,
//            bit_ready, busy, done, l, e, g)
// -----------------------------------------------------------------------------
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_mag_comparator_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  rel_t              rel_q;
  rel_t              rel_next;
  rel_t              cell_rel;
  leg_t              leg_q;

  logic              cell_lt;
  logic              cell_eq;
  logic              cell_gt;
  logic              accept;
  logic              last_bit;
  logic              restart;

  bit_cmp_cell u_cell (
    .a  (bus.a_bit),
    .b  (bus.b_bit),
    .lt (cell_lt),
    .eq (cell_eq),
    .gt (cell_gt)
  );

  assign accept   = bus.bit_valid && (state_q == SHIFT);
  assign last_bit = accept && (cnt_q == CNT_LAST);
  // start is honoured only outside SHIFT; in DONE it chains straight into
  // the next comparison.
  assign restart  = bus.start && (state_q != SHIFT);

  always_comb begin
    cell_rel = REL_EQ;
    if (cell_eq)      cell_rel = REL_EQ;
    else if (cell_lt) cell_rel = REL_LT;
    else if (cell_gt) cell_rel = REL_GT;
  end

  // MSB first: the first differing bit decides and the decision is sticky.
  // LSB first: every differing bit overwrites, so the most significant
  // difference (the last one seen) wins.
  always_comb begin
    rel_next = rel_q;
    if (MSB_FIRST) begin
      if (rel_q == REL_EQ) rel_next = cell_rel;
    end else begin
      if (cell_rel != REL_EQ) rel_next = cell_rel;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    state_d = bus.start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rel_q   <= REL_EQ;
      leg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (restart) begin
        cnt_q <= '0;
        rel_q <= REL_EQ;
      end else if (accept && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
        rel_q <= rel_next;
      end
      // The final bit is folded in combinationally so the result lands on
      // the same edge that enters DONE.
      if (last_bit) leg_q <= rel_to_leg(rel_next);
    end
  end

  assign bus.bit_ready = (state_q == SHIFT);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = (state_q == DONE);
  assign bus.l         = leg_q.l;
  assign bus.e         = leg_q.e;
  assign bus.g         = leg_q.g;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_mag_comparator
// Two WIDTH=4 comparators (MSB first and LSB first) share one serial stream.
// A behavioural model reassembles the operands as integers and compares them;
// the DUT outputs are checked against it every cycle, and directed scenarios
// add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_serial_mag_comparator;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, bit_valid, a_bit, b_bit;

  serial_mag_comparator_if if_m ();
  serial_mag_comparator_if if_l ();

  assign if_m.start = start;  assign if_m.bit_valid = bit_valid;
  assign if_m.a_bit = a_bit;  assign if_m.b_bit     = b_bit;
  assign if_l.start = start;  assign if_l.bit_valid = bit_valid;
  assign if_l.a_bit = a_bit;  assign if_l.b_bit     = b_bit;

  serial_mag_comparator #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .bus(if_m)
  );
  serial_mag_comparator #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bus(if_l)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;
  int start_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: index 0 = MSB-first device, 1 = LSB-first device.
  logic       m_act  [2];
  logic       m_done [2];
  logic       m_l [2], m_e [2], m_g [2];
  int         m_cnt  [2];
  int         m_a [2], m_b [2];

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_act[d] = 0; m_done[d] = 0; m_cnt[d] = 0;
        m_l[d] = 0; m_e[d] = 0; m_g[d] = 0;
        m_a[d] = 0; m_b[d] = 0;
      end else begin
        m_done[d] = 0;
        if (m_act[d]) begin
          if (bit_valid) begin
            if (d == 0) begin
              m_a[d] = m_a[d] * 2 + int'(a_bit);
              m_b[d] = m_b[d] * 2 + int'(b_bit);
            end else begin
              m_a[d] = m_a[d] + (int'(a_bit) << m_cnt[d]);
              m_b[d] = m_b[d] + (int'(b_bit) << m_cnt[d]);
            end
            m_cnt[d]++;
            if (m_cnt[d] == W) begin
              m_act[d]  = 0;
              m_done[d] = 1;
              m_l[d] = (m_a[d] <  m_b[d]);
              m_e[d] = (m_a[d] == m_b[d]);
              m_g[d] = (m_a[d] >  m_b[d]);
            end
          end
        end else if (start) begin
          m_act[d] = 1; m_cnt[d] = 0; m_a[d] = 0; m_b[d] = 0;
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_done[d] = 0; m_cnt[d] = 0;
      m_l[d] = 0; m_e[d] = 0; m_g[d] = 0; m_a[d] = 0; m_b[d] = 0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic cmp_dut(input string tag, input int d,
                         input logic br, input logic bz, input logic dn,
                         input logic l, input logic e, input logic g);
    check_bit({tag, ".bit_ready"}, br, m_act[d]);
    check_bit({tag, ".busy"},      bz, m_act[d]);
    check_bit({tag, ".done"},      dn, m_done[d]);
    check_bit({tag, ".l"},         l,  m_l[d]);
    check_bit({tag, ".e"},         e,  m_e[d]);
    check_bit({tag, ".g"},         g,  m_g[d]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp_dut("msb", 0, if_m.bit_ready, if_m.busy, if_m.done, if_m.l, if_m.e, if_m.g);
        cmp_dut("lsb", 1, if_l.bit_ready, if_l.busy, if_l.done, if_l.l, if_l.e, if_l.g);
      end
    end
  end

  // All drive tasks start and end at 1 time unit after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // Stream vectors: bit 3 is sent first.
  task automatic send_bits(input logic [3:0] a, input logic [3:0] b,
                           input int bub_at, input int bub_len, input int start_at);
    for (int i = 0; i < W; i++) begin
      if (i == bub_at) begin
        bit_valid = 1'b0;
        repeat (bub_len) begin @(posedge clk); #1; end
      end
      start     = (i == start_at);
      bit_valid = 1'b1;
      a_bit     = a[3-i];
      b_bit     = b[3-i];
      @(posedge clk); #1;
    end
    start     = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at_cyc);
    bit seen;
    seen   = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (if_m.done) begin
        seen   = 1'b1;
        at_cyc = cyc;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_done: got no done expected done within %0d cycles", budget);
    end
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  initial begin
    int dc, d1;
    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check_bit("rst.bit_ready", if_m.bit_ready, 1'b0);
    check_bit("rst.done",      if_m.done,      1'b0);
    check_bit("rst.e",         if_m.e,         1'b0);
    check_bit("rst.lsb_e",     if_l.e,         1'b0);
    realign();
    rst_n = 1'b1;
    realign();

    // A=1010 B=1001 MSB first -> g; LSB device sees A=5 B=9 -> l.
    pulse_start();
    send_bits(4'b1010, 4'b1001, -1, 0, -1);
    wait_done(10, dc);
    check_int("s1.latency", dc - start_cyc + 1, 5);
    check_bit("s1.msb_g", if_m.g, 1'b1);
    check_bit("s1.msb_l", if_m.l, 1'b0);
    check_bit("s1.msb_e", if_m.e, 1'b0);
    check_bit("s1.model_g", m_g[0], 1'b1);
    check_bit("s1.lsb_l", if_l.l, 1'b1);
    realign();

    // Equal operands.
    pulse_start();
    send_bits(4'b0110, 4'b0110, -1, 0, -1);
    wait_done(10, dc);
    check_bit("s2.msb_e", if_m.e, 1'b1);
    check_bit("s2.lsb_e", if_l.e, 1'b1);
    realign();

    // A=0011 B=0100: decided at bit 2 -> l; LSB device sees 12 vs 2 -> g.
    pulse_start();
    send_bits(4'b0011, 4'b0100, -1, 0, -1);
    wait_done(10, dc);
    check_bit("s3.msb_l", if_m.l, 1'b1);
    check_bit("s3.lsb_g", if_l.g, 1'b1);
    check_bit("s3.model_l", m_l[0], 1'b1);
    realign();

    // A=0001 B=1000 sent LSB first -> LSB device l; MSB device sees 8 vs 1 -> g.
    pulse_start();
    send_bits(4'b1000, 4'b0001, -1, 0, -1);
    wait_done(10, dc);
    check_bit("s4.lsb_l", if_l.l, 1'b1);
    check_bit("s4.model_lsb_l", m_l[1], 1'b1);
    check_bit("s4.msb_g", if_m.g, 1'b1);
    realign();

    // First scenario with a 2-cycle bubble and a stray start mid-stream.
    pulse_start();
    send_bits(4'b1010, 4'b1001, 2, 2, 1);
    wait_done(12, dc);
    check_int("s5.latency", dc - start_cyc + 1, 7);
    check_bit("s5.msb_g", if_m.g, 1'b1);
    realign();

    // Reset after 2 of 4 bits.
    pulse_start();
    bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    @(posedge clk); #1;
    a_bit = 1'b0; b_bit = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("s6.busy", if_m.busy, 1'b0);
    check_bit("s6.g",    if_m.g,    1'b0);
    check_bit("s6.lsb_l", if_l.l,   1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_bit("s6.no_done", if_m.done, 1'b0);
    end
    realign();
    pulse_start();
    send_bits(4'b1100, 4'b1011, -1, 0, -1);
    wait_done(10, dc);
    check_bit("s6.msb_g", if_m.g, 1'b1);
    check_bit("s6.lsb_l", if_l.l, 1'b1);
    realign();

    // Back-to-back: start during the DONE cycle.
    pulse_start();
    send_bits(4'b0010, 4'b0100, -1, 0, -1);
    d1 = cyc;
    check_bit("s7.first_done", if_m.done, 1'b1);
    check_bit("s7.first_l",    if_m.l,    1'b1);
    pulse_start();
    check_bit("s7.ready_no_gap", if_m.bit_ready, 1'b1);
    send_bits(4'b1111, 4'b0111, -1, 0, -1);
    wait_done(10, dc);
    check_int("s7.spacing", dc - d1, W + 1);
    check_bit("s7.msb_g", if_m.g, 1'b1);
    check_bit("s7.lsb_g", if_l.g, 1'b1);
    realign();

    repeat (3) begin @(posedge clk); #1; end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_mag_comparator.md
# serial_mag_comparator

Bit-serial N-bit magnitude comparator that consumes operand pairs one bit per handshake and reports less/equal/greater once all WIDTH bits are in. It is the serial-stream counterpart of the team's single-bit comparator. It sits on the consuming end of a bit-serial link, e.g. behind a shift register or UART-style deserialiser, where parallel operands are never assembled. Internally it cascades a one-bit compare cell with a sticky decision register.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal values ≥ 1.
- MSB_FIRST, 1. If 1, bits arrive MSB first; if 0, LSB first.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  begin a new comparison; sampled only in IDLE or DONE.
- bit_valid  in  1  a_bit/b_bit carry a valid bit pair.
- a_bit  in  1  serial bit of operand A.
- b_bit  in  1  serial bit of operand B.
- bit_ready  out  1  block accepts a bit pair this cycle; high only in SHIFT.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse; the comparison has finished.
- l  out  1  A < B, registered, held until the next done.
- e  out  1  A == B, registered, held until the next done.
- g  out  1  A > B, registered, held until the next done.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 → SHIFT; clear the bit counter; set the working result to "equal".
  - SHIFT: a bit pair is accepted when bit_valid && bit_ready. When the accepted count reaches WIDTH → DONE.
  - DONE: lasts one cycle. start=1 in this cycle → SHIFT with the same clearing as from IDLE; otherwise → IDLE.
- start while in SHIFT is ignored; the comparison in flight continues.
- Per-bit cell: lt = ~a & b, gt = a & ~b; equal otherwise.
- MSB_FIRST=1:
  - The first accepted pair with lt or gt sets the sticky decision.
  - All later pairs are still consumed but do not change the decision.
- MSB_FIRST=0: every pair with lt or gt overwrites the working result. The last differing bit, which is the most significant, wins.
- At the SHIFT→DONE transition, l/e/g load the working result. Exactly one of them is then high.
- Bit counter width is $clog2(WIDTH+1). The counter never wraps; it stops at WIDTH.

## Timing
- Reset values: state=IDLE, bit_ready=0, busy=0, done=0, l=0, e=0, g=0, counter=0, working result=equal.
- l/e/g stay all-zero until the first done after reset.
- start sampled at edge k → bit_ready=1 and busy=1 from cycle k+1.
- Last bit accepted at edge m → done=1 and new l/e/g visible in cycle m+1; bit_ready=0 in that cycle.
- Minimum start→done latency is WIDTH+1 cycles with bit_valid held high. Bubbles on bit_valid add one cycle each.
- Back-to-back operation: start during the DONE cycle gives bit_ready=1 in the next cycle, with no idle gap.
- rst_n low at any edge, including mid-SHIFT:
  - the FSM returns to IDLE and all outputs take their reset values on that edge;
  - the partial comparison is discarded;
  - no done pulse is issued.
- a_bit/b_bit are don't-care when bit_valid=0 or bit_ready=0.

## Structure
- Shared package cmp_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - 2-bit relation encoding: REL_EQ, REL_LT, REL_GT;
  - function rel_to_leg() mapping the encoding to l/e/g.
- Sub-module bit_cmp_cell: combinational single-bit compare, with inputs a, b and outputs lt, eq, gt. It is instantiated once.
- The top level holds the FSM, the counter, the sticky/overwrite result register and the output registers.

## Test plan
- WIDTH=4, MSB_FIRST=1, A=1010, B=1001, bit_valid held high → done 5 cycles after start with g=1, l=0, e=0.
- WIDTH=4, A=B=0110 → e=1. Then A=0011, B=0100 → l=1; the decision is fixed at the second bit and the later bits 1/0 are ignored.
- MSB_FIRST=0, WIDTH=4, A=0001, B=1000 sent LSB first → l=1, because the final overwrite comes from the MSB.
- Same as the first scenario with bit_valid dropped for 2 cycles mid-stream → done delayed by exactly 2 cycles with the same result. Also pulse start mid-SHIFT → no effect.
- rst_n asserted after 2 of 4 bits → next edge gives IDLE, l/e/g=0 and no done. A new start then completes normally.
- start asserted in the DONE cycle with a new operand pair → second done exactly WIDTH+1 cycles after the first, with the correct new result.
